// File: rtl/mips_run_ctrl_if.sv
// Board-button / breakpoint / core-enable bundle between the run controller and its neighbours.
// The slave side is the controller; the master side drives buttons and the core PC.
interface mips_run_ctrl_if #(
  parameter int PC_WIDTH    = 32,
  parameter int BURST_WIDTH = 8,
  parameter int CNT_WIDTH   = 32
);
  logic                   change_i;
  logic                   step_i;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   bp_en;
  logic [PC_WIDTH-1:0]    bp_addr;
  logic [PC_WIDTH-1:0]    pc;
  logic                   cpu_en;
  logic [1:0]             mode;
  logic                   bp_hit;
  logic [CNT_WIDTH-1:0]   exec_count;

  modport master (
    output change_i, step_i, burst_len, bp_en, bp_addr, pc,
    input  cpu_en, mode, bp_hit, exec_count
  );

  modport slave (
    input  change_i, step_i, burst_len, bp_en, bp_addr, pc,
    output cpu_en, mode, bp_hit, exec_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/step controller for the MIPS core: debounced run/halt and step buttons drive the
// core clock enable through free-run, single-step, N-step burst and breakpoint halts.

// Synchroniser plus debounce filter; emits a one-cycle pulse on an accepted rising level.
module mips_run_ctrl_deb #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic          filt;
  logic [CW-1:0] tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
      filt <= 1'b0;
      tmr  <= CW'(CYCLES - 1);
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == filt) begin
        tmr <= CW'(CYCLES - 1);
      end else if (tmr == '0) begin
        filt <= sync[1];
        tmr  <= CW'(CYCLES - 1);
        rise <= sync[1];
      end else begin
        tmr <= tmr - CW'(1);
      end
    end
  end
endmodule

// state | meaning
// HALT  | core stopped, waiting for a change or step press
// RUN   | free run until change press or breakpoint
// STEP  | one enabled cycle, then HALT
// BURST | burst_len enabled cycles, abortable by change press or breakpoint
module mips_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PC_WIDTH        = 32,
  parameter int BURST_WIDTH     = 8,
  parameter int CNT_WIDTH       = 32,
  parameter int RESET_MODE      = 0
) (
  input logic              clk,
  input logic              rst,
  mips_run_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BURST = 2'b11
  } state_t;

  state_t                 state, state_nx;
  logic                   skip, skip_nx;
  logic                   bp_hit_q, bp_hit_nx;
  logic [BURST_WIDTH-1:0] cnt, cnt_nx;
  logic [CNT_WIDTH-1:0]   exec_q;
  logic [PC_WIDTH-1:0]    pc_w;
  logic                   chg_p, stp_p, bp_match, en;

  mips_run_ctrl_deb #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_chg (
    .clk(clk), .rst(rst), .raw(bus.change_i), .rise(chg_p)
  );
  mips_run_ctrl_deb #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_stp (
    .clk(clk), .rst(rst), .raw(bus.step_i), .rise(stp_p)
  );

  assign pc_w     = bus.pc;
  assign bp_match = bus.bp_en & (pc_w == bus.bp_addr) & ~skip;
  // A change press aborts a burst before the cycle executes; elsewhere it only redirects the FSM.
  assign en       = (state != HALT) & ~bp_match & ~((state == BURST) & chg_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (RESET_MODE != 0) ? HALT : RUN;
      skip     <= 1'b0;
      bp_hit_q <= 1'b0;
      cnt      <= '0;
      exec_q   <= '0;
    end else begin
      state    <= state_nx;
      skip     <= skip_nx;
      bp_hit_q <= bp_hit_nx;
      cnt      <= cnt_nx;
      if (en) exec_q <= exec_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nx  = state;
    skip_nx   = skip;
    bp_hit_nx = bp_hit_q;
    cnt_nx    = cnt;
    if (en) skip_nx = 1'b0;
    unique case (state)
      HALT: begin
        if (chg_p) begin
          state_nx  = RUN;
          skip_nx   = 1'b1;
          bp_hit_nx = 1'b0;
        end else if (stp_p) begin
          skip_nx   = 1'b1;
          bp_hit_nx = 1'b0;
          if (bus.burst_len <= BURST_WIDTH'(1)) begin
            state_nx = STEP;
          end else begin
            state_nx = BURST;
            cnt_nx   = bus.burst_len;
          end
        end
      end
      RUN: begin
        if (chg_p) begin
          state_nx = HALT;
        end else if (bp_match) begin
          state_nx  = HALT;
          bp_hit_nx = 1'b1;
        end
      end
      STEP: state_nx = HALT;
      BURST: begin
        if (chg_p) begin
          state_nx = HALT;
        end else if (bp_match) begin
          state_nx  = HALT;
          bp_hit_nx = 1'b1;
        end else begin
          cnt_nx = cnt - BURST_WIDTH'(1);
          if (cnt == BURST_WIDTH'(1)) state_nx = HALT;
        end
      end
      default: state_nx = HALT;
    endcase
  end

  assign bus.cpu_en     = en;
  assign bus.mode       = state;
  assign bus.bp_hit     = bp_hit_q;
  assign bus.exec_count = exec_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: a window-based button model and a steps-remaining run model
// are checked against the DUT every cycle, plus hand-computed checkpoints per scenario.
module tb_mips_run_ctrl;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mips_run_ctrl_if #(.PC_WIDTH(32), .BURST_WIDTH(8), .CNT_WIDTH(32)) bus ();

  mips_run_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .PC_WIDTH(32), .BURST_WIDTH(8), .CNT_WIDTH(32), .RESET_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: raw input history per edge, plus halted / kind / steps-left run state.
  bit          raw_c [0:8191];
  bit          raw_s [0:8191];
  bit          rr    [0:8191];
  int          eidx = 0;
  bit          m_valid = 0;
  bit          m_halted, m_skip, m_bphit, m_fc, m_fs, m_chg, m_stp;
  int          m_kind;  // 1 run, 2 step, 3 burst
  int          m_left;
  logic [31:0] m_exec;

  function automatic bit synced(input int x, input bit which);
    if (x < 2) return 1'b0;
    if (rr[x-1] || rr[x-2]) return 1'b0;
    return which ? raw_s[x-2] : raw_c[x-2];
  endfunction

  // Level flips at edge e when the last DEB evaluated samples all disagree with it.
  function automatic bit flips(input int e, input bit which, input bit filt);
    if (e < DEB - 1) return 1'b0;
    for (int j = 0; j < DEB; j++)
      if (rr[e-j] || synced(e - j, which) == filt) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_en();
    if (m_halted) return 1'b0;
    if (bus.bp_en && bus.pc == bus.bp_addr && !m_skip) return 1'b0;
    if (m_kind == 3 && m_chg) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit e_en, bpm, nc, ns;
    raw_c[eidx] = bus.change_i;
    raw_s[eidx] = bus.step_i;
    rr[eidx]    = rst;
    if (rst) begin
      m_halted = 1'b0; m_kind = 1; m_left = 0; m_skip = 1'b0; m_bphit = 1'b0;
      m_exec = '0; m_fc = 1'b0; m_fs = 1'b0; m_chg = 1'b0; m_stp = 1'b0;
      m_valid = 1'b1;
    end else begin
      e_en = exp_en();
      bpm  = bus.bp_en && bus.pc == bus.bp_addr && !m_skip;
      if (e_en) begin
        m_exec = m_exec + 1;
        m_skip = 1'b0;
      end
      if (m_halted) begin
        if (m_chg) begin
          m_halted = 1'b0; m_kind = 1; m_skip = 1'b1; m_bphit = 1'b0;
        end else if (m_stp) begin
          m_halted = 1'b0; m_skip = 1'b1; m_bphit = 1'b0;
          m_left = (bus.burst_len <= 1) ? 1 : int'(bus.burst_len);
          m_kind = (m_left == 1) ? 2 : 3;
        end
      end else if (m_chg) begin
        m_halted = 1'b1;
      end else if (bpm && m_kind != 2) begin
        m_halted = 1'b1; m_bphit = 1'b1;
      end else if (m_kind != 1) begin
        m_left--;
        if (m_left == 0) m_halted = 1'b1;
      end
      nc = flips(eidx, 1'b0, m_fc);
      ns = flips(eidx, 1'b1, m_fs);
      if (nc) m_fc = !m_fc;
      if (ns) m_fs = !m_fs;
      m_chg = nc && m_fc;
      m_stp = ns && m_fs;
    end
    eidx++;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_cpu_en", bus.cpu_en, exp_en());
      chk("cyc_mode", bus.mode, m_halted ? 0 : m_kind);
      chk("cyc_bp_hit", bus.bp_hit, m_bphit);
      chk("cyc_exec_count", bus.exec_count, m_exec);
    end
  end

  initial begin
    logic [31:0] base;
    rst = 1'b1;
    bus.change_i = 1'b0; bus.step_i = 1'b0; bus.burst_len = '0;
    bus.bp_en = 1'b0; bus.bp_addr = '0; bus.pc = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    tick(20);
    chk("t1_exec_count", bus.exec_count, 20);
    chk("t1_mode", bus.mode, 2'b01);

    bus.change_i = 1'b1; tick(3); bus.change_i = 1'b0; tick(12);
    chk("t2_glitch_mode", bus.mode, 2'b01);
    bus.change_i = 1'b1; tick(10);
    chk("t2_halt_mode", bus.mode, 2'b00);
    chk("t2_halt_cpu_en", bus.cpu_en, 1'b0);
    bus.change_i = 1'b0; tick(10);

    base = bus.exec_count;
    bus.burst_len = 8'd0; bus.step_i = 1'b1; tick(8); bus.step_i = 1'b0; tick(10);
    chk("t3_step_exec", bus.exec_count, base + 1);
    chk("t3_step_mode", bus.mode, 2'b00);

    base = bus.exec_count;
    bus.burst_len = 8'd5; bus.step_i = 1'b1; tick(8); bus.step_i = 1'b0; tick(12);
    chk("t4_burst_exec", bus.exec_count, base + 5);
    chk("t4_burst_mode", bus.mode, 2'b00);

    base = bus.exec_count;
    bus.step_i = 1'b1; tick(3); bus.change_i = 1'b1; tick(8);
    bus.step_i = 1'b0; bus.change_i = 1'b0; tick(12);
    chk("t4_abort_exec", bus.exec_count, base + 2);
    chk("t4_abort_mode", bus.mode, 2'b00);

    bus.bp_en = 1'b1; bus.bp_addr = 32'h10; bus.pc = 32'h8;
    bus.change_i = 1'b1; tick(6);
    chk("t5_latency_before", bus.mode, 2'b00);
    tick(1);
    chk("t5_latency_at", bus.mode, 2'b01);
    tick(5); bus.change_i = 1'b0; tick(5);
    bus.pc = 32'h10; #1;
    chk("t5_bp_cpu_en", bus.cpu_en, 1'b0);
    tick(1);
    chk("t5_bp_mode", bus.mode, 2'b00);
    chk("t5_bp_hit", bus.bp_hit, 1'b1);

    base = bus.exec_count;
    bus.burst_len = 8'd0; bus.step_i = 1'b1; tick(8); bus.step_i = 1'b0; tick(10);
    chk("t5_step_exec", bus.exec_count, base + 1);
    chk("t5_step_bp_hit", bus.bp_hit, 1'b0);
    chk("t5_step_mode", bus.mode, 2'b00);

    base = bus.exec_count;
    bus.change_i = 1'b1; tick(8); bus.change_i = 1'b0; tick(10);
    chk("t5_resume_exec", bus.exec_count, base + 1);
    chk("t5_resume_mode", bus.mode, 2'b00);
    chk("t5_resume_bp_hit", bus.bp_hit, 1'b1);

    bus.bp_en = 1'b0; bus.burst_len = 8'd5; bus.step_i = 1'b1; tick(9);
    bus.step_i = 1'b0; rst = 1'b1; bus.change_i = 1'b1; tick(1);
    chk("t6_rst_mode", bus.mode, 2'b01);
    chk("t6_rst_exec", bus.exec_count, 0);
    chk("t6_rst_bp_hit", bus.bp_hit, 1'b0);
    tick(1); rst = 1'b0; tick(3); bus.change_i = 1'b0; tick(12);
    chk("t6_no_pulse_mode", bus.mode, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
